program_loader: RTL and testbench
=================================

// Module: program_loader
//
// PURPOSE
// Boot-time stage directly upstream of cpu_top. Accepts a byte stream (host/bench
// side), assembles 16-bit instruction words, writes them into instruction memory
// from address 0, verifies an XOR checksum, then releases the CPU from reset.
// CPU stays in reset for the whole load and on any load error.
//
// PARAMETERS
// ADDR_W   8   instruction memory address width; capacity = 2**ADDR_W words
//
// PORTS
// clk          in   1       system clock, all state on rising edge
// reset        in   1       asynchronous, active-high; clears all state
// start        in   1       1-cycle pulse: begin load (honoured in IDLE/DONE/ERROR only)
// byte_in      in   8       stream byte
// byte_valid   in   1       byte_in valid
// byte_ready   out  1       loader accepts byte; transfer = byte_valid & byte_ready
// imem_we      out  1       instruction memory write strobe, 1 cycle per word
// imem_addr    out  ADDR_W  write address
// imem_wdata   out  16      write data
// cpu_reset    out  1       reset to cpu_top; 1 = CPU held in reset
// done         out  1       load completed, checksum good
// error        out  1       load aborted (length overflow or checksum mismatch)
//
// BEHAVIOUR
// - Stream format: LEN_HI, LEN_LO (N, 16-bit big-endian), then N words, each
//   HI byte then LO byte, then one CHK byte = XOR of all word bytes (header excluded).
// - Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1,
//   done=0, error=0; FSM in IDLE.
// - FSM: IDLE -start-> LEN_HI -> LEN_LO -> (N=0: CHECK | N>2**ADDR_W: ERROR |
//   else DATA_HI) ; DATA_HI -> DATA_LO -> (last word: CHECK | else DATA_HI);
//   CHECK -> DONE (match) | ERROR (mismatch). DONE/ERROR -start-> LEN_HI.
// - State advances only on an accepted byte (except IDLE/DONE/ERROR on start).
// - byte_ready is a registered output: 1 in LEN_HI/LEN_LO/DATA_HI/DATA_LO/CHECK,
//   0 otherwise; byte_valid without ready is ignored, bytes are never dropped.
// - Word write: cycle after the LO byte is accepted, imem_we=1 for exactly one
//   cycle with imem_addr=word index (0..N-1), imem_wdata={HI,LO}. imem_addr/wdata
//   hold their last value when imem_we=0.
// - Checksum accumulator cleared on start; XORs each accepted data byte.
// - done/cpu_reset: cycle after CHK byte accepted with match -> done=1, cpu_reset=0.
//   Mismatch -> error=1, cpu_reset stays 1. Overflow -> error=1 the cycle after
//   LEN_LO is accepted, no imem writes issued.
// - start in DONE/ERROR: next cycle done=0, error=0, cpu_reset=1, byte counter and
//   checksum cleared, state LEN_HI. start while busy (LEN_HI..CHECK) is ignored.
// - start and byte_valid in the same IDLE cycle: byte not accepted (ready=0 in IDLE).
// - Reset asserted mid-load: immediate return to reset values; words already
//   written remain in memory (not undone); next start begins a clean load.
// - N = 2**ADDR_W is legal: last write at address 2**ADDR_W-1, no wrap.
//
// TESTING
// 1. start; bytes 00 03 12 34 AB CD 0F 00 4F -> imem_we x3: (0,1234),(1,ABCD),
//    (2,0F00); then done=1, cpu_reset=0, error=0.
// 2. Same stream, CHK=00 -> error=1, done=0, cpu_reset stays 1; 3 writes still seen.
// 3. start; bytes 00 00 00 -> no imem_we, done=1, cpu_reset=0.
// 4. ADDR_W=8; bytes 01 01 (N=257) -> error=1 next cycle, byte_ready=0, no writes.
// 5. Test 1 stream with random byte_valid gaps and a start pulse mid-load -> identical
//    writes/result, start ignored.
// 6. reset pulse after 2 data words of test 1 -> all outputs at reset values,
//    cpu_reset=1; fresh start + full test-1 stream -> done=1, correct writes.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The host drives the stream (master); the loader consumes it (slave).
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_reset, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output cpu_reset, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> 16-bit imem words,
// XOR checksum verify, then CPU reset release.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI,
    S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [16:0]       cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              acc;
  logic [16:0]       cnt_inc;
  logic [16:0]       n_ext;

  assign acc     = bus.byte_valid & ready_q;
  assign cnt_inc = cnt_q + 17'd1;
  assign n_ext   = {1'b0, len_hi_q, bus.byte_in};

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    hi_d      = hi_q;
    chk_d     = chk_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d   = S_LEN_HI;
          done_d    = 1'b0;
          err_d     = 1'b0;
          cpu_rst_d = 1'b1;
          cnt_d     = '0;
          chk_d     = '0;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_hi_d = bus.byte_in;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d = n_ext[15:0];
          if (n_ext == 17'd0) begin
            state_d = S_CHECK;
          end else if (n_ext > CAP) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (acc) begin
          hi_d    = bus.byte_in;
          chk_d   = chk_q ^ bus.byte_in;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (acc) begin
          chk_d   = chk_q ^ bus.byte_in;
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = {hi_q, bus.byte_in};
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == {1'b0, len_q}) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (acc) begin
          if (bus.byte_in == chk_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // ready is registered from the next state so it is glitch-free
    ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                              S_DATA_LO, S_CHECK};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      chk_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      chk_q     <= chk_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_reset  = cpu_rst_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: stream-level reference model,
// per-cycle write scoreboard, directed and random loads.
module tb_program_loader;
  localparam int ADDR_W = 8;

  typedef logic [7:0] u8_t;
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];
  wr_t wlog[$];

  u8_t t1[$] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB,
                 8'hCD, 8'h0F, 8'h00, 8'h4F};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    wr_t e;
    chk("cpu_reset_vs_done", 32'(bus.cpu_reset), 32'(!bus.done));
    if (bus.imem_we === 1'b1) begin
      wlog.push_back('{int'(bus.imem_addr), int'(bus.imem_wdata)});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), e.addr);
        chk("write_data", 32'(bus.imem_wdata), e.data);
      end
    end
  end

  // Reference model: parse the stream, queue the writes, predict outcome
  task automatic model(input u8_t s[$], output bit e_done,
                       output bit e_err, output int nw);
    int  n;
    u8_t x;
    n = {s[0], s[1]};
    x = 8'h00;
    nw = 0;
    if (n > (1 << ADDR_W)) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    nw = n;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{k, int'({s[2+2*k], s[3+2*k]})});
      x = x ^ s[2+2*k] ^ s[3+2*k];
    end
    e_done = (s[2+2*n] == x);
    e_err  = !e_done;
  endtask

  task automatic send_byte(input u8_t b, input bit pulse_start);
    bit acc;
    int w;
    w = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bus.start      = pulse_start;
    forever begin
      acc = bus.byte_ready;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (acc) break;
      w++;
      if (w > 50) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %0h never accepted", b);
        break;
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic load(input u8_t s[$], input int gap_max,
                      input int mid_at, input int send_cnt,
                      input string tag);
    bit e_done, e_err;
    int nw;
    model(s, e_done, e_err, nw);
    for (int i = 0; i < send_cnt; i++) begin
      if (i > 0)
        repeat ($urandom_range(0, gap_max)) begin
          bus.byte_valid = 1'b0;
          bus.byte_in    = 8'($urandom);
          @(posedge clk);
          #1;
        end
      send_byte(s[i], (i == 0) || (i == mid_at));
      if (i >= 2 && i < 2 + 2 * nw && ((i - 2) % 2) == 1)
        chk({tag, "_we_timing"}, 32'(bus.imem_we), 1);
    end
    if (send_cnt == s.size()) begin
      chk({tag, "_done"}, 32'(bus.done), 32'(e_done));
      chk({tag, "_error"}, 32'(bus.error), 32'(e_err));
      chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!e_done));
      chk({tag, "_ready_low"}, 32'(bus.byte_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_writes_seen"}, exp_q.size(), 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
    chk({tag, "_we"}, 32'(bus.imem_we), 0);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.imem_wdata), 0);
    chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_error"}, 32'(bus.error), 0);
  endtask

  task automatic check_t1_log(input string tag);
    chk({tag, "_nwrites"}, wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk({tag, "_w0"}, {wlog[0].addr[15:0], wlog[0].data[15:0]}, 32'h0000_1234);
      chk({tag, "_w1"}, {wlog[1].addr[15:0], wlog[1].data[15:0]}, 32'h0001_ABCD);
      chk({tag, "_w2"}, {wlog[2].addr[15:0], wlog[2].data[15:0]}, 32'h0002_0F00);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    u8_t s[$];
    u8_t x, b;
    int  n;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;

    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_ready", 32'(bus.byte_ready), 0);
    bus.byte_valid = 1'b0;

    wlog.delete();
    load(t1, 0, -1, t1.size(), "t1");
    check_t1_log("t1");
    chk("t1_done_lit", 32'(bus.done), 1);

    s = t1;
    s[s.size()-1] = 8'h00;
    wlog.delete();
    load(s, 0, -1, s.size(), "t2");
    check_t1_log("t2");
    chk("t2_error_lit", 32'(bus.error), 1);

    s = '{8'h00, 8'h00, 8'h00};
    wlog.delete();
    load(s, 1, -1, s.size(), "t3");
    chk("t3_nwrites", wlog.size(), 0);

    s = '{8'h01, 8'h01};
    wlog.delete();
    load(s, 1, -1, s.size(), "t4");
    chk("t4_error_lit", 32'(bus.error), 1);
    chk("t4_nwrites", wlog.size(), 0);

    wlog.delete();
    load(t1, 3, 5, t1.size(), "t5");
    check_t1_log("t5");

    load(t1, 0, -1, 6, "t6");
    @(posedge clk);
    #1;
    chk("t6_pending_writes", exp_q.size(), 1);
    exp_q.delete();
    #2 reset = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wlog.delete();
    load(t1, 1, -1, t1.size(), "t6b");
    check_t1_log("t6b");

    // Full-capacity load: last word lands at the top address
    s = '{8'h01, 8'h00};
    x = 8'h00;
    for (int k = 0; k < 512; k++) begin
      b = 8'($urandom);
      s.push_back(b);
      x ^= b;
    end
    s.push_back(x);
    wlog.delete();
    load(s, 0, -1, s.size(), "cap");
    chk("cap_nwrites", wlog.size(), 256);
    if (wlog.size() == 256)
      chk("cap_last_addr", wlog[255].addr, 255);

    s = '{8'hFF, 8'hFF};
    load(s, 0, -1, s.size(), "ovf_max");

    for (int r = 0; r < 16; r++) begin
      n = $urandom_range(0, 6);
      s = '{};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < 2 * n; k++) begin
        b = 8'($urandom);
        s.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 3) == 0)
        x ^= 8'($urandom_range(1, 255));
      s.push_back(x);
      load(s, 2, ($urandom_range(0, 1) == 1) ? 3 : -1, s.size(), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
